// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move-entry controller: validates placed moves, alternates turns,
// keeps both boards and resolves win / draw / timeout forfeit.
module ttt_move_ctrl #(
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic [3:0] Cell,
    input  logic       Place,
    output logic [8:0] XBoard,
    output logic [8:0] OBoard,
    output logic       Turn,
    output logic       Reject,
    output logic [1:0] Winner,
    output logic [3:0] MoveCnt,
    output logic       Qi,
    output logic       Qw,
    output logic       Qc,
    output logic       Qd
);
    // One-hot encoding so corrupted state values are detectable and recover.
    typedef enum logic [3:0] {
        S_INI   = 4'b0001,
        S_WAIT  = 4'b0010,
        S_CHECK = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t          r_state, w_state_nxt;
    logic [8:0]      r_xb, r_ob, w_xb_nxt, w_ob_nxt;
    logic            r_turn, w_turn_nxt;
    logic            r_rej, w_rej_nxt;
    logic [1:0]      r_win, w_win_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [TO_W-1:0] r_timer, w_timer_nxt;

    logic [8:0] w_sel;
    logic [8:0] w_mover;
    logic       w_legal;

    function automatic logic f_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Cells above 8 shift out to an all-zero select and are rejected by the range test.
    assign w_sel   = 9'd1 << Cell;
    assign w_legal = (Cell <= 4'd8) && (((r_xb | r_ob) & w_sel) == 9'd0);
    assign w_mover = r_turn ? r_ob : r_xb;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_INI;
            r_xb    <= '0;
            r_ob    <= '0;
            r_turn  <= 1'b0;
            r_rej   <= 1'b0;
            r_win   <= 2'b00;
            r_cnt   <= 4'd0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_xb    <= w_xb_nxt;
            r_ob    <= w_ob_nxt;
            r_turn  <= w_turn_nxt;
            r_rej   <= w_rej_nxt;
            r_win   <= w_win_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xb_nxt    = r_xb;
        w_ob_nxt    = r_ob;
        w_turn_nxt  = r_turn;
        w_rej_nxt   = 1'b0;
        w_win_nxt   = r_win;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        case (r_state)
            S_INI: begin
                w_xb_nxt   = '0;
                w_ob_nxt   = '0;
                w_turn_nxt = 1'b0;
                w_win_nxt  = 2'b00;
                w_cnt_nxt  = 4'd0;
                if (Start) begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = '0;
                end
            end
            S_WAIT: begin
                if (Place && w_legal) begin
                    if (r_turn) w_ob_nxt = r_ob | w_sel;
                    else        w_xb_nxt = r_xb | w_sel;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    w_state_nxt = S_CHECK;
                end else begin
                    w_rej_nxt = Place;
                    if (TIMEOUT > 0) begin
                        if (r_timer == TO_LAST) begin
                            // Idle player forfeits to the opponent.
                            w_win_nxt   = r_turn ? 2'b01 : 2'b10;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_timer_nxt = r_timer + 1'b1;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (f_line(w_mover)) begin
                    w_win_nxt   = r_turn ? 2'b10 : 2'b01;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == 4'd9) begin
                    w_win_nxt   = 2'b11;
                    w_state_nxt = S_DONE;
                end else begin
                    w_turn_nxt  = ~r_turn;
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                if (Ack) begin
                    w_state_nxt = S_INI;
                    w_xb_nxt    = '0;
                    w_ob_nxt    = '0;
                    w_turn_nxt  = 1'b0;
                    w_win_nxt   = 2'b00;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_INI;
                w_xb_nxt    = '0;
                w_ob_nxt    = '0;
                w_turn_nxt  = 1'b0;
                w_win_nxt   = 2'b00;
                w_cnt_nxt   = 4'd0;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        Qi = 1'b0;
        Qw = 1'b0;
        Qc = 1'b0;
        Qd = 1'b0;
        case (r_state)
            S_INI:   Qi = 1'b1;
            S_WAIT:  Qw = 1'b1;
            S_CHECK: Qc = 1'b1;
            S_DONE:  Qd = 1'b1;
            default: Qi = 1'b1;
        endcase
    end

    assign XBoard  = r_xb;
    assign OBoard  = r_ob;
    assign Turn    = r_turn;
    assign Reject  = r_rej;
    assign Winner  = r_win;
    assign MoveCnt = r_cnt;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: directed game scenarios plus random play, compared
// each cycle against a cell-array game model.
module tb_ttt_move_ctrl;
    localparam int TMO = 16;

    logic       Clk = 1'b0;
    logic       Reset, Start, Ack, Place;
    logic [3:0] Cell;
    logic [8:0] XBoard, OBoard;
    logic       Turn, Reject;
    logic [1:0] Winner;
    logic [3:0] MoveCnt;
    logic       Qi, Qw, Qc, Qd;

    always #5 Clk = ~Clk;

    ttt_move_ctrl #(.TIMEOUT(TMO), .TO_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Cell(Cell), .Place(Place),
        .XBoard(XBoard), .OBoard(OBoard), .Turn(Turn), .Reject(Reject), .Winner(Winner),
        .MoveCnt(MoveCnt), .Qi(Qi), .Qw(Qw), .Qc(Qc), .Qd(Qd)
    );

    int checks = 0;
    int errors = 0;

    // Game model: phase 0 idle, 1 awaiting move, 2 judging, 3 finished.
    int m_phase, m_turn, m_rej, m_win, m_cnt, m_timer;
    int m_cell[9];
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int has_line(input int p);
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == p && m_cell[lines[l][1]] == p && m_cell[lines[l][2]] == p)
                return 1;
        return 0;
    endfunction

    task automatic clear_game();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = 0;
        m_win  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit ak, input bit pl, input int c);
        bit legal;
        if (rst) begin
            clear_game();
            m_phase = 0;
            m_rej   = 0;
            m_timer = 0;
            return;
        end
        m_rej = 0;
        case (m_phase)
            0: begin
                clear_game();
                if (st) begin m_phase = 1; m_timer = 0; end
            end
            1: begin
                legal = 0;
                if (pl && c <= 8) legal = (m_cell[c] == 0);
                if (legal) begin
                    m_cell[c] = m_turn + 1;
                    m_cnt++;
                    m_phase = 2;
                end else begin
                    if (pl) m_rej = 1;
                    if (m_timer == TMO - 1) begin
                        m_win   = m_turn ? 1 : 2;
                        m_phase = 3;
                    end else m_timer++;
                end
            end
            2: begin
                if (has_line(m_turn + 1) != 0) begin
                    m_win = m_turn ? 2 : 1; m_phase = 3;
                end else if (m_cnt == 9) begin
                    m_win = 3; m_phase = 3;
                end else begin
                    m_turn  = 1 - m_turn;
                    m_timer = 0;
                    m_phase = 1;
                end
            end
            default: begin
                if (ak) begin m_phase = 0; clear_game(); end
            end
        endcase
    endtask

    task automatic cyc(input bit rst = 0, input bit st = 0, input bit ak = 0,
                       input bit pl = 0, input int c = 0);
        logic [8:0] ex, eo;
        Reset = rst; Start = st; Ack = ak; Place = pl; Cell = 4'(c);
        @(posedge Clk);
        model_edge(rst, st, ak, pl, c);
        #1;
        for (int i = 0; i < 9; i++) begin
            ex[i] = (m_cell[i] == 1);
            eo[i] = (m_cell[i] == 2);
        end
        chk("xboard", XBoard, ex);
        chk("oboard", OBoard, eo);
        chk("turn", Turn, m_turn);
        chk("reject", Reject, m_rej);
        chk("winner", Winner, m_win);
        chk("movecnt", MoveCnt, m_cnt);
        chk("state", {Qi, Qw, Qc, Qd}, 4'b1000 >> m_phase);
    endtask

    task automatic place(input int c);
        cyc(.pl(1), .c(c));
    endtask

    task automatic move(input int c);
        place(c);
        cyc();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Ack = 1'b0; Place = 1'b0; Cell = 4'd0;

        cyc(.rst(1));
        chk("rst_qi", Qi, 1'b1);
        chk("rst_board", {XBoard, OBoard}, 18'd0);

        // X wins on the top row; Place during CHECK and DONE must be ignored.
        cyc(.st(1));
        place(0);
        cyc(.pl(1), .c(5));
        chk("chk_place_ign", OBoard, 9'h000);
        move(3); move(1); move(4); move(2);
        chk("xwin_winner", Winner, 2'b01);
        chk("xwin_qd", Qd, 1'b1);
        chk("xwin_xb", XBoard, 9'h007);
        chk("xwin_ob", OBoard, 9'h018);
        chk("xwin_cnt", MoveCnt, 4'd5);
        cyc(.pl(1), .c(6));
        chk("done_place_rej", Reject, 1'b0);
        chk("done_place_xb", XBoard, 9'h007);
        cyc(.ak(1));
        chk("ack_qi", Qi, 1'b1);
        chk("ack_board", {XBoard, OBoard}, 18'd0);

        // Illegal moves, Ack outside DONE, reset mid-WAIT.
        cyc(.st(1));
        cyc(.ak(1));
        chk("ack_wait_qw", Qw, 1'b1);
        move(4);
        place(4);
        chk("occ_reject", Reject, 1'b1);
        chk("occ_turn", Turn, 1'b1);
        chk("occ_ob", OBoard, 9'h000);
        cyc();
        chk("reject_pulse", Reject, 1'b0);
        place(9);
        chk("range_reject", Reject, 1'b1);
        chk("range_cnt", MoveCnt, 4'd1);
        cyc(.rst(1));
        chk("midrst_qi", {Qi, Qw, Qc, Qd}, 4'b1000);
        chk("midrst_out", {XBoard, OBoard, Turn, Reject, Winner, MoveCnt}, 26'd0);

        // Draw filling the board.
        cyc(.st(1));
        move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6);
        chk("draw_pre_qd", Qd, 1'b0);
        move(8);
        chk("draw_winner", Winner, 2'b11);
        chk("draw_cnt", MoveCnt, 4'd9);
        chk("draw_xb", XBoard, 9'h18D);
        chk("draw_ob", OBoard, 9'h072);
        cyc(.ak(1));

        // Timeout forfeit, then a legal move on the expiry cycle.
        cyc(.st(1));
        repeat (TMO - 1) cyc();
        chk("to_pre_qw", Qw, 1'b1);
        cyc();
        chk("to_qd", Qd, 1'b1);
        chk("to_winner", Winner, 2'b10);
        cyc(.ak(1));
        cyc(.st(1));
        repeat (TMO - 1) cyc();
        place(5);
        chk("to_last_qc", Qc, 1'b1);
        chk("to_last_cnt", MoveCnt, 4'd1);
        cyc();
        chk("to_last_qw", Qw, 1'b1);
        chk("to_last_win", Winner, 2'b00);
        cyc(.rst(1));

        // Random play against the model.
        for (int n = 0; n < 4000; n++) begin
            cyc(.rst($urandom_range(0, 199) == 0),
                .st($urandom_range(0, 3) == 0),
                .ak($urandom_range(0, 3) == 0),
                .pl($urandom_range(0, 1) == 1),
                .c(int'($urandom_range(0, 11))));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
